// File: rtl/apb_reg_slv.sv
// APB3 slave front-end for the register bank: RW control registers stored here,
// RO status words taken from the RO register outputs, with wait states and strobes.
module apb_reg_slv #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int RW_NUM   = 4,
  parameter int RO_NUM   = 4,
  parameter int WAIT_CYC = 1,
  parameter logic [RW_NUM*DATA_W-1:0] RW_DEFAULT = {RW_NUM*DATA_W{1'b0}}
) (
  input  logic                     clk_reg,
  input  logic                     rst_reg,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDR_W-1:0]        paddr,
  input  logic [DATA_W-1:0]        pwdata,
  output logic [DATA_W-1:0]        prdata,
  output logic                     pready,
  output logic                     pslverr,
  input  logic [RO_NUM*DATA_W-1:0] ro_data_in,
  output logic [RW_NUM*DATA_W-1:0] rw_data_out,
  output logic [RO_NUM-1:0]        ro_rd_pulse,
  output logic [RW_NUM-1:0]        rw_wr_pulse
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] RO_BASE = IDX_W'(64);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state_reg;
  logic [3:0]        cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              write_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic              ready_reg;
  logic              slverr_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [RW_NUM-1:0] wr_pulse_reg;
  logic [RO_NUM-1:0] rd_pulse_reg;

  logic [DATA_W-1:0] rw_reg [RW_NUM];

  logic [RW_NUM-1:0] rw_hit;
  logic [RO_NUM-1:0] ro_hit;
  logic              rw_any;
  logic              ro_any;
  logic              err_next;
  logic [DATA_W-1:0] rdata_next;
  logic              commit_wr;
  logic              addr_lsb_unused;

  // Byte lane bits of the address carry no meaning for word registers.
  assign addr_lsb_unused = ^paddr[1:0];

  // Address decode of the captured word index.
  generate
    for (genvar gi = 0; gi < RW_NUM; gi++) begin : g_rw_dec
      assign rw_hit[gi] = (idx_reg == IDX_W'(gi));
      assign rw_data_out[gi*DATA_W +: DATA_W] = rw_reg[gi];
    end
    for (genvar gi = 0; gi < RO_NUM; gi++) begin : g_ro_dec
      assign ro_hit[gi] = (idx_reg == RO_BASE + IDX_W'(gi));
    end
  endgenerate

  assign rw_any   = |rw_hit;
  assign ro_any   = |ro_hit;
  assign err_next = write_reg ? ~rw_any : ~(rw_any | ro_any);

  always_comb begin
    rdata_next = '0;
    for (int i = 0; i < RW_NUM; i++) begin
      if (rw_hit[i]) rdata_next = rw_reg[i];
    end
    for (int i = 0; i < RO_NUM; i++) begin
      if (ro_hit[i]) rdata_next = ro_data_in[i*DATA_W +: DATA_W];
    end
    if (write_reg) rdata_next = '0;
  end

  // The write lands on the edge that closes DONE, only if the master is still selecting us.
  assign commit_wr = (state_reg == DONE) && psel && write_reg;

  always_ff @(posedge clk_reg or posedge rst_reg) begin
    if (rst_reg) begin
      for (int i = 0; i < RW_NUM; i++) begin
        rw_reg[i] <= RW_DEFAULT[i*DATA_W +: DATA_W];
      end
    end else if (commit_wr) begin
      for (int i = 0; i < RW_NUM; i++) begin
        if (rw_hit[i]) rw_reg[i] <= wdata_reg;
      end
    end
  end

  always_ff @(posedge clk_reg or posedge rst_reg) begin
    if (rst_reg) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      write_reg    <= 1'b0;
      wdata_reg    <= '0;
      ready_reg    <= 1'b0;
      slverr_reg   <= 1'b0;
      rdata_reg    <= '0;
      wr_pulse_reg <= '0;
      rd_pulse_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (psel && !penable) begin
            idx_reg   <= paddr[ADDR_W-1:2];
            write_reg <= pwrite;
            wdata_reg <= pwdata;
            cnt_reg   <= 4'(WAIT_CYC);
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state_reg <= IDLE;
          end else if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            state_reg    <= DONE;
            ready_reg    <= 1'b1;
            slverr_reg   <= err_next;
            rdata_reg    <= rdata_next;
            wr_pulse_reg <= write_reg ? rw_hit : '0;
            rd_pulse_reg <= write_reg ? '0 : ro_hit;
          end
        end
        DONE: begin
          state_reg    <= IDLE;
          ready_reg    <= 1'b0;
          slverr_reg   <= 1'b0;
          rdata_reg    <= '0;
          wr_pulse_reg <= '0;
          rd_pulse_reg <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A master that drops psel in DONE aborts: the registered response is masked.
  assign pready      = ready_reg & psel;
  assign pslverr     = pready & slverr_reg;
  assign prdata      = pready ? rdata_reg : '0;
  assign rw_wr_pulse = pready ? wr_pulse_reg : '0;
  assign ro_rd_pulse = pready ? rd_pulse_reg : '0;

endmodule

// File: tb/tb_apb_reg_slv.sv
// Self-checking bench for apb_reg_slv: directed cases, WAIT_CYC sweep, random traffic vs. a model.
module tb_apb_reg_slv;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int NRW = 4;
  localparam int NRO = 4;
  localparam int W   = 1;
  localparam logic [NRW*DW-1:0] DEF = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'hA5A5_0001};

  logic clk_reg = 1'b0;
  logic rst_reg;
  logic psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic pready, pslverr;
  logic [NRO*DW-1:0] ro_data;
  logic [NRW*DW-1:0] rw_data_out;
  logic [NRO-1:0] ro_rd_pulse;
  logic [NRW-1:0] rw_wr_pulse;

  always #5 clk_reg = ~clk_reg;

  apb_reg_slv #(.ADDR_W(AW), .DATA_W(DW), .RW_NUM(NRW), .RO_NUM(NRO), .WAIT_CYC(W), .RW_DEFAULT(DEF)) dut (
    .clk_reg(clk_reg), .rst_reg(rst_reg), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .ro_data_in(ro_data), .rw_data_out(rw_data_out), .ro_rd_pulse(ro_rd_pulse), .rw_wr_pulse(rw_wr_pulse)
  );

  // Wait-state sweep instances on the shared bus, each with its own select.
  logic           sw_psel   [3];
  logic           sw_pready [3];
  logic           sw_pslverr[3];
  logic [DW-1:0]  sw_prdata [3];
  logic [NRW*DW-1:0] sw_rw  [3];
  logic [NRO-1:0] sw_rd     [3];
  logic [NRW-1:0] sw_wr     [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
      apb_reg_slv #(.ADDR_W(AW), .DATA_W(DW), .RW_NUM(NRW), .RO_NUM(NRO),
                    .WAIT_CYC(gi == 0 ? 0 : (gi == 1 ? 3 : 15)), .RW_DEFAULT(DEF)) u_sw (
        .clk_reg(clk_reg), .rst_reg(rst_reg), .psel(sw_psel[gi]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(sw_prdata[gi]), .pready(sw_pready[gi]),
        .pslverr(sw_pslverr[gi]), .ro_data_in(ro_data), .rw_data_out(sw_rw[gi]),
        .ro_rd_pulse(sw_rd[gi]), .rw_wr_pulse(sw_wr[gi])
      );
    end
  endgenerate

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  // Reference model: register contents plus the outputs expected in the current cycle.
  logic [DW-1:0] m_rw [NRW];
  logic pend;
  int pend_i;
  logic [DW-1:0] pend_d;
  logic e_pready, e_pslverr;
  logic [DW-1:0] e_prdata;
  logic [NRO-1:0] e_rd;
  logic [NRW-1:0] e_wr;
  logic [NRW*DW-1:0] e_rw;

  function automatic logic [NRW*DW-1:0] flat();
    logic [NRW*DW-1:0] v;
    for (int i = 0; i < NRW; i++) v[i*DW +: DW] = m_rw[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NRW; i++) m_rw[i] = DEF[i*DW +: DW];
    pend = 1'b0;
    e_pready = 1'b0; e_pslverr = 1'b0; e_prdata = '0; e_rd = '0; e_wr = '0;
    e_rw = flat();
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_reg) begin
    if (chk_en) begin
      check("pready", 128'(pready), 128'(e_pready));
      check("pslverr", 128'(pslverr), 128'(e_pslverr));
      check("prdata", 128'(prdata), 128'(e_prdata));
      check("rw_wr_pulse", 128'(rw_wr_pulse), 128'(e_wr));
      check("ro_rd_pulse", 128'(ro_rd_pulse), 128'(e_rd));
      check("rw_data_out", 128'(rw_data_out), 128'(e_rw));
    end
  end

  task automatic next_cycle();
    @(posedge clk_reg);
    #1;
    if (pend) begin m_rw[pend_i] = pend_d; pend = 1'b0; end
    e_pready = 1'b0; e_pslverr = 1'b0; e_prdata = '0; e_rd = '0; e_wr = '0;
    e_rw = flat();
  endtask

  task automatic idle(input logic rnd_ro);
    next_cycle();
    psel = 1'b0; penable = 1'b0;
    if (rnd_ro) ro_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int abort_at, input logic twiddle,
                      output int lat, output logic [DW-1:0] rd, output logic err,
                      output logic [NRW-1:0] wp_o, output logic [NRO-1:0] rp_o);
    int idx;
    logic [DW-1:0] rsp;
    logic er;
    logic [NRW-1:0] wp;
    logic [NRO-1:0] rp;
    lat = -1; rd = '0; err = 1'b0; wp_o = '0; rp_o = '0;
    next_cycle();
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    idx = int'(a[AW-1:2]);
    rsp = '0; er = 1'b1; wp = '0; rp = '0;
    if (idx < NRW) begin
      er = 1'b0;
      if (wr) wp[idx] = 1'b1; else rsp = m_rw[idx];
    end else if (idx >= 64 && idx < 64 + NRO && !wr) begin
      er = 1'b0;
      rp[idx-64] = 1'b1;
      rsp = ro_data[(idx-64)*DW +: DW];
    end
    for (int k = 1; k <= W + 2; k++) begin
      next_cycle();
      penable = ($urandom_range(0, 3) != 0);
      if (k == abort_at) begin
        psel = 1'b0; penable = 1'b0;
        #3;
        if (pready === 1'b1) lat = k;
        break;
      end
      if (k == W + 2) begin
        e_pready = 1'b1; e_pslverr = er; e_prdata = rsp; e_wr = wp; e_rd = rp;
        if (wr && !er) begin pend = 1'b1; pend_i = idx; pend_d = d; end
        if (twiddle) ro_data = {$urandom, $urandom, $urandom, $urandom};
      end
      #3;
      if (pready === 1'b1) begin
        lat = k; rd = prdata; err = pslverr; wp_o = rw_wr_pulse; rp_o = ro_rd_pulse;
      end
    end
  endtask

  task automatic sweep(input int k, input int wc);
    int lat;
    logic [DW-1:0] rd;
    lat = -1; rd = '0;
    next_cycle();
    sw_psel[k] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      penable = 1'b1;
      #3;
      if (sw_pready[k] === 1'b1) begin lat = c; rd = sw_prdata[k]; break; end
    end
    next_cycle();
    sw_psel[k] = 1'b0; penable = 1'b0;
    check($sformatf("sweep_lat_w%0d", wc), 128'(lat), 128'(wc + 2));
    check($sformatf("sweep_rd_w%0d", wc), 128'(rd), 128'(32'h2222_0002));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [DW-1:0] rd;
    logic err;
    logic [NRW-1:0] wp;
    logic [NRO-1:0] rp;
    int idx, sel, ab;
    logic [AW-1:0] a;

    rst_reg = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    ro_data = '0;
    for (int k = 0; k < 3; k++) sw_psel[k] = 1'b0;
    model_reset();
    chk_en = 1'b1;
    next_cycle();
    next_cycle();
    rst_reg = 1'b0;

    // Reset default readback and latency
    xfer(1'b0, 12'h000, '0, 0, 1'b0, lat, rd, err, wp, rp);
    check("rd_default_data", 128'(rd), 128'(32'hA5A5_0001));
    check("rd_default_err", 128'(err), 128'(0));
    check("rd_default_lat", 128'(lat), 128'(3));

    // Write then read back
    xfer(1'b1, 12'h004, 32'hDEAD_BEEF, 0, 1'b0, lat, rd, err, wp, rp);
    check("wr_pulse", 128'(wp), 128'(4'b0010));
    check("wr_err", 128'(err), 128'(0));
    idle(1'b0);
    check("wr_visible", 128'(rw_data_out[63:32]), 128'(32'hDEAD_BEEF));
    xfer(1'b0, 12'h004, '0, 0, 1'b0, lat, rd, err, wp, rp);
    check("wr_readback", 128'(rd), 128'(32'hDEAD_BEEF));

    // RO read with sampling of ro_data_in
    idle(1'b0);
    ro_data[95:64] = 32'h1234_5678;
    xfer(1'b0, 12'h108, '0, 0, 1'b1, lat, rd, err, wp, rp);
    check("ro_rd_data", 128'(rd), 128'(32'h1234_5678));
    check("ro_rd_pulse_lit", 128'(rp), 128'(4'b0100));

    // Error responses
    xfer(1'b1, 12'h100, 32'hFFFF_FFFF, 0, 1'b0, lat, rd, err, wp, rp);
    check("wr_ro_err", 128'(err), 128'(1));
    check("wr_ro_pulse", 128'(wp), 128'(0));
    xfer(1'b0, 12'h200, '0, 0, 1'b0, lat, rd, err, wp, rp);
    check("rd_unmapped_err", 128'(err), 128'(1));
    check("rd_unmapped_data", 128'(rd), 128'(0));
    check("rd_unmapped_pulse", 128'(rp), 128'(0));
    idle(1'b0);
    check("err_rw_unchanged", 128'(rw_data_out), 128'({32'h4444_0004, 32'h3333_0003, 32'hDEAD_BEEF, 32'hA5A5_0001}));

    // Abort in T1, then a normal write
    xfer(1'b1, 12'h000, 32'h1111_1111, 1, 1'b0, lat, rd, err, wp, rp);
    check("abort_no_pready", 128'(lat), 128'(-1));
    idle(1'b0);
    check("abort_rw0", 128'(rw_data_out[31:0]), 128'(32'hA5A5_0001));
    xfer(1'b1, 12'h000, 32'h0F0F_0F0F, 0, 1'b0, lat, rd, err, wp, rp);
    check("after_abort_pulse", 128'(wp), 128'(4'b0001));
    idle(1'b0);
    check("after_abort_rw0", 128'(rw_data_out[31:0]), 128'(32'h0F0F_0F0F));

    // Reset while a write to 0x00C is in ACCESS
    next_cycle();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h5555_AAAA;
    next_cycle();
    penable = 1'b1;
    #1;
    rst_reg = 1'b1; psel = 1'b0; penable = 1'b0;
    model_reset();
    next_cycle();
    rst_reg = 1'b0;
    next_cycle();
    check("rst_rw3", 128'(rw_data_out[127:96]), 128'(32'h4444_0004));
    check("rst_rw0", 128'(rw_data_out[31:0]), 128'(32'hA5A5_0001));
    xfer(1'b1, 12'h00C, 32'h7777_8888, 0, 1'b0, lat, rd, err, wp, rp);
    check("post_rst_wr_lat", 128'(lat), 128'(3));

    // Wait-state sweep
    idle(1'b0);
    sweep(0, 0);
    sweep(1, 3);
    sweep(2, 15);

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        idx = $urandom_range(0, NRW - 1);
      end else if (sel < 7) begin
        idx = 64 + $urandom_range(0, NRO - 1);
      end else begin
        do idx = $urandom_range(0, 1023); while (idx < NRW || (idx >= 64 && idx < 64 + NRO));
      end
      a = AW'(idx * 4 + $urandom_range(0, 3));
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, W + 2) : 0;
      xfer(1'($urandom_range(0, 1)), a, $urandom, ab, 1'($urandom_range(0, 1)), lat, rd, err, wp, rp);
      if ($urandom_range(0, 2) == 0) idle(1'b1);
    end
    idle(1'b0);
    idle(1'b0);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_reg_slv.md
# apb_reg_slv

APB3 slave front-end for the register bank. It decodes bus transfers onto a set of read/write control registers, which it stores internally, and a set of read-only status words, which it takes from the RO register outputs. It sits directly downstream of the RO register instances, consuming their `data_out`, and directly upstream of the block logic that consumes the RW register values. It adds a configurable wait-state count, error response, and per-register access strobes.

## Interface
- `ADDR_W`, 12: PADDR width; only bits [ADDR_W-1:2] decoded.
- `DATA_W`, 32: register/bus data width.
- `RW_NUM`, 4: number of RW registers (1..32).
- `RO_NUM`, 4: number of RO inputs (1..32).
- `WAIT_CYC`, 1: wait states inserted before PREADY (0..15).
- `RW_DEFAULT`, {RW_NUM*DATA_W{1'b0}}: flattened reset values; RW[i] = bits [i*DATA_W +: DATA_W].
- `clk_reg`  in  1  register-bank clock; all logic on the rising edge.
- `rst_reg`  in  1  asynchronous, active-high reset.
- `psel`  in  1  APB select.
- `penable`  in  1  APB enable.
- `pwrite`  in  1  1 = write.
- `paddr`  in  ADDR_W  byte address.
- `pwdata`  in  DATA_W  write data.
- `prdata`  out  DATA_W  read data; valid only while `pready` is high.
- `pready`  out  1  transfer completes this cycle.
- `pslverr`  out  1  error response; qualified by `pready`.
- `ro_data_in`  in  RO_NUM*DATA_W  flattened RO register `data_out` values.
- `rw_data_out`  out  RW_NUM*DATA_W  flattened RW register contents.
- `ro_rd_pulse`  out  RO_NUM  one-cycle pulse on a successful read of RO[i].
- `rw_wr_pulse`  out  RW_NUM  one-cycle pulse on a successful write of RW[i].

## Operation
- Address map, word index = paddr[ADDR_W-1:2]:
  - RW[i] at byte offset 0x000 + 4i.
  - RO[i] at byte offset 0x100 + 4i.
  - Every other address is unmapped.
- paddr[1:0] is ignored.
- Error cases, all of which set `pslverr`=1 with `pready`:
  - Read of an unmapped address: `prdata`=0, no side effects.
  - Write to an unmapped address: no state change.
  - Write to an RO address: no state change, no pulses.
- FSM states IDLE, ACCESS, DONE:
  - IDLE: on `psel`=1 and `penable`=0 (setup phase), capture `paddr`, `pwrite` and `pwdata`, load the wait counter with WAIT_CYC, and go to ACCESS.
  - ACCESS: while the counter is nonzero, decrement it. At zero, register the response, then go to DONE. `pready` is a registered output and is high only in DONE.
  - DONE, with `pready` high for exactly 1 cycle:
    - Perform the write, if any, on the closing edge.
    - Pulse `rw_wr_pulse[i]` or `ro_rd_pulse[i]` in this same cycle, for a successful access only.
    - Return to IDLE.
  - Back-to-back: a new setup phase is accepted in the IDLE cycle that follows DONE.
- Abort: if `psel` drops while in ACCESS or DONE, return to IDLE. No write, no pulses, `pready` stays 0.
- `rdata` is a combinational read of the captured index, registered on entry to DONE. The RO value returned is `ro_data_in` as sampled on the edge entering DONE.
- `pslverr`, `prdata` and all pulses are 0 whenever `pready`=0.

## Timing
- Reset values, while `rst_reg`=1 or after its assertion:
  - `pready`=0, `pslverr`=0, `prdata`=0.
  - All pulses 0.
  - `rw_data_out` = RW_DEFAULT.
  - FSM in IDLE.
- Reset mid-transfer discards the pending write. The bus must restart with a new setup phase.
- Cycle numbering: setup phase in cycle T0, access phase begins in T1.
- `pready`=1 in cycle T1+WAIT_CYC+1. Transfer latency from setup is WAIT_CYC+2 cycles, including the setup cycle.
- The written value is visible on `rw_data_out` from cycle T1+WAIT_CYC+2.
- `rw_wr_pulse` and `ro_rd_pulse` are coincident with `pready`.
- `penable` low during ACCESS or DONE with `psel` high is ignored; only `psel` aborts.

## Test plan
- Reset with RW_DEFAULT[0]=0xA5A5_0001, then read 0x000 -> `prdata`=0xA5A5_0001, `pslverr`=0, `pready` exactly in cycle T0+3 (WAIT_CYC=1).
- Write 0xDEAD_BEEF to 0x004, then read 0x004:
  - `rw_wr_pulse`=4'b0010 for one cycle with `pready`.
  - `rw_data_out[63:32]`=0xDEAD_BEEF the next cycle.
  - Readback matches.
- Set `ro_data_in` word 2 = 0x1234_5678 and read 0x108 -> `prdata`=0x1234_5678, `ro_rd_pulse`=4'b0100 coincident with `pready`.
- Write to 0x100 (RO) and read 0x200 (unmapped):
  - Both return `pslverr`=1.
  - The read returns `prdata`=0.
  - `rw_data_out` is unchanged and all pulses stay 0.
- Drop `psel` in T1 of a write to 0x000 -> FSM returns to IDLE, no `pready`, RW[0] unchanged. A following write then completes normally.
- Assert `rst_reg` in the ACCESS state of a write to 0x00C -> RW[3] = default, all outputs 0. Sweep WAIT_CYC in {0, 3, 15} and check `pready` lands at T0+WAIT_CYC+2.
